// File: rtl/angle_reducer_pkg.sv
// angle_reducer_pkg: shared constants and FSM state encoding for the
// angle reducer. Angles are fixed point with FXP_SHIFT fractional bits
// (Q8.23 on the raw input side).
package angle_reducer_pkg;

    localparam int FXP_SHIFT = 23;

    localparam int unsigned PI      = 32'd26353589;
    localparam int unsigned TWO_PI  = 32'd52707178;
    localparam int unsigned HALF_PI = 32'd13176794;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        MOD,
        FOLD_PI,
        FOLD_HALF,
        ISSUE
    } state_t;

endpackage

// File: rtl/angle_reducer.sv
// angle_reducer: reduces a signed Q8.23 angle to [0, PI/2] (+1 lsb) for a
// downstream cosine stage, plus a flag telling that stage to negate its
// result. Pipeline: |x| -> x mod 2*PI (6 shifted conditional subtracts)
// -> fold about PI -> fold about PI/2 -> issue.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   in_angle is valid (taken only while in_ready)
//   in_ready   idle, can accept a new angle
//   in_angle   raw angle, Q8.23 signed
//   start      level request to cosine stage, held until cos_ready
//   cos_ready  cosine stage acknowledge (only looked at while start is high)
//   regAngle   reduced angle, Q1.23, stable while start is high
//   neg_flag   cosine result must be negated, stable while start is high
//   quadrant   {fold about PI taken, fold about PI/2 taken}; present only
//              when ANGLE_RED_QUAD_EN is defined
module angle_reducer
    import angle_reducer_pkg::*;
#(
    parameter int W  = 24,
    parameter int IW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_angle,
    output logic          start,
    input  logic          cos_ready,
    output logic [W-1:0]  regAngle,
    output logic          neg_flag
`ifdef ANGLE_RED_QUAD_EN
    ,
    output logic [1:0]    quadrant
`endif
);

    localparam int XW = IW + 1;

    localparam logic [IW:0] PI_X      = XW'(PI);
    localparam logic [IW:0] TWO_PI_X  = XW'(TWO_PI);
    localparam logic [IW:0] HALF_PI_X = XW'(HALF_PI);

    // Most negative input has no positive twin; clamp it to the max positive.
    localparam logic [IW-1:0] MOST_NEG = {1'b1, {(IW-1){1'b0}}};
    localparam logic [IW:0]   SAT_POS  = {2'b00, {(IW-1){1'b1}}};

    state_t        state;
    logic [IW:0]   x;
    logic [2:0]    k;
    logic [IW-1:0] x_neg;

    function automatic logic [IW:0] cond_sub(input logic [IW:0] a, input logic [IW:0] b);
        return (a >= b) ? (a - b) : a;
    endfunction

    assign in_ready = (state == IDLE);
    assign x_neg    = -x[IW-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            x        <= '0;
            k        <= '0;
            start    <= 1'b0;
            regAngle <= '0;
            neg_flag <= 1'b0;
`ifdef ANGLE_RED_QUAD_EN
            quadrant <= 2'b00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x     <= {1'b0, in_angle};
                        state <= ABS;
                    end
                end
                ABS: begin
                    if (x[IW-1]) begin
                        x <= (x[IW-1:0] == MOST_NEG) ? SAT_POS : {1'b0, x_neg};
                    end
                    k     <= 3'd5;
                    state <= MOD;
                end
                MOD: begin
                    // Restoring-division style: subtract 2*PI*2^k where it fits,
                    // leaving x mod 2*PI after k reaches 0.
                    x <= cond_sub(x, TWO_PI_X << k);
                    if (k == 3'd0) state <= FOLD_PI;
                    else           k     <= k - 3'd1;
                end
                FOLD_PI: begin
                    if (x >= PI_X) x <= TWO_PI_X - x;
`ifdef ANGLE_RED_QUAD_EN
                    quadrant[1] <= (x >= PI_X);
`endif
                    state <= FOLD_HALF;
                end
                FOLD_HALF: begin
                    if (x >= HALF_PI_X) begin
                        x        <= PI_X - x;
                        neg_flag <= 1'b1;
                    end else begin
                        neg_flag <= 1'b0;
                    end
`ifdef ANGLE_RED_QUAD_EN
                    quadrant[0] <= (x >= HALF_PI_X);
`endif
                    state <= ISSUE;
                end
                ISSUE: begin
                    // First ISSUE cycle registers the request; cos_ready is
                    // only honoured once start is actually visible.
                    if (!start) begin
                        start    <= 1'b1;
                        regAngle <= x[W-1:0];
                    end else if (cos_ready) begin
                        start <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_reducer.sv
module tb_angle_reducer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_angle;
    logic        start;
    logic        cos_ready;
    logic [23:0] regAngle;
    logic        neg_flag;
`ifdef ANGLE_RED_QUAD_EN
    logic [1:0]  quadrant;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [23:0] ang;
        logic        neg;
    } exp_t;
    exp_t sb[$];

    angle_reducer #(.W(24), .IW(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .start     (start),
        .cos_ready (cos_ready),
        .regAngle  (regAngle),
        .neg_flag  (neg_flag)
`ifdef ANGLE_RED_QUAD_EN
        ,
        .quadrant  (quadrant)
`endif
    );

    always #5 clock = ~clock;

    // Reference: |a| (saturated), true modulo, then the two folds.
    function automatic exp_t model(input logic [31:0] a);
        exp_t   e;
        longint v;
        v = longint'($signed(a));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        v = v % 64'sd52707178;
        if (v >= 64'sd26353589) v = 64'sd52707178 - v;
        if (v >= 64'sd13176794) begin
            v = 64'sd26353589 - v;
            e.neg = 1'b1;
        end else begin
            e.neg = 1'b0;
        end
        e.ang = v[23:0];
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input exp_t e);
        sb.push_back(e);
        in_valid = 1'b1;
        in_angle = a;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!start && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
    endtask

    task automatic ack();
        cos_ready = 1'b1;
        @(posedge clock); #1;
        cos_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; cos_ready = 1'b0; in_angle = '0;
        #12;
        total++; if (start !== 1'b0) $display("FAIL reset_start got %b want 0", start); else passed++;
        total++; if (regAngle !== 24'd0) $display("FAIL reset_angle got %0d want 0", regAngle); else passed++;
        total++; if (neg_flag !== 1'b0) $display("FAIL reset_neg got %b want 0", neg_flag); else passed++;
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_known();
        logic [31:0] ang_t [4] = '{32'd0, 32'd26353589, 32'hFC800000, 32'd13176794};
        logic [23:0] exp_a [4] = '{24'd0, 24'd0, 24'd6013078, 24'd13176795};
        logic        exp_n [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            int   c;
            e.ang = exp_a[i]; e.neg = exp_n[i];
            send(ang_t[i], e);
            wait_start(c);
            total++; if (c != 10) $display("FAIL known%0d_latency got %0d want 10", i, c); else passed++;
            e = sb.pop_front();
            total++; if (regAngle !== e.ang) $display("FAIL known%0d_angle got %0d want %0d", i, regAngle, e.ang); else passed++;
            total++; if (neg_flag !== e.neg) $display("FAIL known%0d_neg got %b want %b", i, neg_flag, e.neg); else passed++;
            ack();
            total++; if (start !== 1'b0 || in_ready !== 1'b1) $display("FAIL known%0d_done start=%b ready=%b want 0/1", i, start, in_ready); else passed++;
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   c;
        send(32'h80000000, model(32'h80000000));
        wait_start(c);
        e = sb.pop_front();
        total++; if (c != 10) $display("FAIL sat_latency got %0d want 10", c); else passed++;
        total++; if ($isunknown({start, regAngle, neg_flag}) || regAngle > 24'd13176795)
            $display("FAIL sat_range got %0d want <= 13176795 and no X", regAngle); else passed++;
        total++; if (regAngle !== e.ang || neg_flag !== e.neg)
            $display("FAIL sat_value got %0d/%b want %0d/%b", regAngle, neg_flag, e.ang, e.neg); else passed++;
        ack();
    endtask

    task automatic test_hold();
        exp_t        e;
        int          c;
        int          bad = 0;
        logic [23:0] held;
        send(32'd40000000, model(32'd40000000));
        wait_start(c);
        e = sb.pop_front();
        held = regAngle;
        total++; if (regAngle !== e.ang) $display("FAIL hold_value got %0d want %0d", regAngle, e.ang); else passed++;
        repeat (20) begin
            @(posedge clock); #1;
            if (start !== 1'b1 || regAngle !== held) bad++;
        end
        total++; if (bad != 0) $display("FAIL hold_stable got %0d unstable cycles want 0", bad); else passed++;
        ack();
        total++; if (start !== 1'b0 || in_ready !== 1'b1) $display("FAIL hold_release start=%b ready=%b want 0/1", start, in_ready); else passed++;
    endtask

    task automatic test_in_valid_ignored();
        exp_t e;
        int   c;
        int   busy_ready = 0;
        int   spurious = 0;
        send(32'd70000000, model(32'd70000000));
        in_valid = 1'b1; in_angle = 32'd5;
        repeat (5) begin
            @(posedge clock); #1;
            if (in_ready !== 1'b0) busy_ready++;
        end
        in_valid = 1'b0;
        total++; if (busy_ready != 0) $display("FAIL busy_ready got %0d ready cycles want 0", busy_ready); else passed++;
        wait_start(c);
        e = sb.pop_front();
        total++; if (regAngle !== e.ang || neg_flag !== e.neg)
            $display("FAIL ignore_value got %0d/%b want %0d/%b", regAngle, neg_flag, e.ang, e.neg); else passed++;
        ack();
        repeat (15) begin
            @(posedge clock); #1;
            if (start !== 1'b0) spurious++;
        end
        total++; if (spurious != 0) $display("FAIL ignore_queued got %0d start cycles want 0", spurious); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            exp_t        e;
            int          c;
            logic [31:0] a;
            a = $urandom();
            cos_ready = 1'b1;
            send(a, model(a));
            wait_start(c);
            e = sb.pop_front();
            total++; if (c != 10) $display("FAIL b2b%0d_latency got %0d want 10", i, c); else passed++;
            total++; if (regAngle !== e.ang || neg_flag !== e.neg)
                $display("FAIL b2b%0d_value a=%h got %0d/%b want %0d/%b", i, a, regAngle, neg_flag, e.ang, e.neg); else passed++;
            @(posedge clock); #1;
            total++; if (start !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL b2b%0d_one_cycle start=%b ready=%b want 0/1", i, start, in_ready); else passed++;
            cos_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   c;
        int   spurious = 0;
        send(32'd90000000, model(32'd90000000));
        void'(sb.pop_back());
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        total++; if (start !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midreset_async start=%b ready=%b want 0/1", start, in_ready); else passed++;
        #2 reset = 1'b0;
        repeat (15) begin
            @(posedge clock); #1;
            if (start !== 1'b0 || in_ready !== 1'b1) spurious++;
        end
        total++; if (spurious != 0) $display("FAIL midreset_discard got %0d bad cycles want 0", spurious); else passed++;
        e.ang = 24'd13176795; e.neg = 1'b1;
        send(32'd13176794, e);
        wait_start(c);
        e = sb.pop_front();
        total++; if (c != 10) $display("FAIL midreset_latency got %0d want 10", c); else passed++;
        total++; if (regAngle !== e.ang || neg_flag !== e.neg)
            $display("FAIL midreset_value got %0d/%b want %0d/%b", regAngle, neg_flag, e.ang, e.neg); else passed++;
        ack();
    endtask

    initial begin
        test_reset();
        test_known();
        test_saturate();
        test_hold();
        test_in_valid_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
